// File: rtl/branch_resolve_queue_pkg.sv
// branch_pkg: shared predictor encodings, control states and default sizes
package branch_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  typedef enum logic {IDLE = 1'b0, UPD_WAIT = 1'b1} ctl_t;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 16;
  function automatic logic ctr_taken(ctr_t s);
    return s[1];
  endfunction
endpackage

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: predictor request/update and resolved-branch handshake bundle
interface branch_resolve_queue_if;
  logic pred_req;
  logic pred_in;
  logic req_ready;
  logic br_valid;
  logic br_taken;
  logic br_ready;
  logic upd_result;
  logic upd_taken;
  modport master (
    output pred_req, pred_in, br_valid, br_taken,
    input  req_ready, br_ready, upd_result, upd_taken
  );
  modport slave (
    input  pred_req, pred_in, br_valid, br_taken,
    output req_ready, br_ready, upd_result, upd_taken
  );
endinterface

// File: rtl/branch_resolve_queue_pred_fifo.sv
// pred_fifo: DEPTH x 1-bit in-order prediction FIFO with explicit occupancy
module pred_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_push,
  input  logic           i_pop,
  input  logic           i_din,
  output logic           o_head,
  output logic [PTR_W:0] o_occ,
  output logic           o_full
);
  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wp, r_rp;
  logic [PTR_W:0]   r_occ;
  logic             w_wr;
  assign o_full = r_occ == (PTR_W+1)'(DEPTH);
  assign w_wr   = i_push && !o_full;
  assign o_head = r_mem[r_rp];
  assign o_occ  = r_occ;
  // storage and pointers; the head is read before a same-edge write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= r_wp + PTR_W'(1);
      end
      if (i_pop) r_rp <= r_rp + PTR_W'(1);
      r_occ <= r_occ + (PTR_W+1)'(w_wr) - (PTR_W+1)'(i_pop);
    end
  end
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: pairs queued predictions with resolved outcomes and schedules predictor updates
module branch_resolve_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_queue_if.slave bus,
  output logic                  mispredict,
  output logic                  overflow,
  output logic [PTR_W:0]        occupancy,
  output logic [CNT_W-1:0]      branch_cnt,
  output logic [CNT_W-1:0]      mispred_cnt
);
  ctl_t             r_state, w_state_nx;
  logic             r_req_d, r_dir, r_mispredict, r_overflow;
  logic [CNT_W-1:0] r_bcnt, r_mcnt;
  logic             w_head, w_full, w_pending, w_xfer, w_miss;
  pred_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_req_d),
    .i_pop  (w_xfer),
    .i_din  (bus.pred_in),
    .o_head (w_head),
    .o_occ  (occupancy),
    .o_full (w_full)
  );
  assign w_pending      = r_state == UPD_WAIT;
  assign bus.req_ready  = ({1'b0, occupancy} + (PTR_W+2)'(r_req_d)) < (PTR_W+2)'(DEPTH);
  assign bus.br_ready   = (occupancy != '0) && !w_pending;
  assign w_xfer         = bus.br_valid && bus.br_ready;
  assign w_miss         = w_head != bus.br_taken;
  assign bus.upd_result = w_pending && !bus.pred_req;
  assign bus.upd_taken  = r_dir;
  assign mispredict     = r_mispredict;
  assign overflow       = r_overflow;
  assign branch_cnt     = r_bcnt;
  assign mispred_cnt    = r_mcnt;
  // control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end
  // an update waits in UPD_WAIT until the predictor has a request-free cycle
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = (r_state == IDLE) ? (w_xfer ? UPD_WAIT : IDLE) : (bus.upd_result ? IDLE : UPD_WAIT);
  end
  // prediction capture timing, outcome bookkeeping and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_d      <= 1'b0;
      r_dir        <= 1'b0;
      r_mispredict <= 1'b0;
      r_overflow   <= 1'b0;
      r_bcnt       <= '0;
      r_mcnt       <= '0;
    end else begin
      r_req_d      <= bus.pred_req;
      r_mispredict <= w_xfer && w_miss;
      if (r_req_d && w_full) r_overflow <= 1'b1;
      if (w_xfer) begin
        r_dir <= bus.br_taken;
        if (~&r_bcnt) r_bcnt <= r_bcnt + CNT_W'(1);
        if (w_miss && ~&r_mcnt) r_mcnt <= r_mcnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: scoreboard bench for the branch resolve queue
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mispredict, overflow;
  logic [2:0]       occupancy;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;
  int               checks = 0;
  int               failures = 0;
  bit               sb_q[$];
  bit               m_req_d, m_pend, m_dir, m_mis, m_ovf, m_xfer;
  int               m_bcnt, m_mcnt;
  branch_resolve_queue_if bus();
  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mispredict  (mispredict),
    .overflow    (overflow),
    .occupancy   (occupancy),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    sb_q.delete();
    m_req_d = 0;
    m_pend  = 0;
    m_dir   = 0;
    m_mis   = 0;
    m_ovf   = 0;
    m_xfer  = 0;
    m_bcnt  = 0;
    m_mcnt  = 0;
  endtask
  task automatic chk_regs();
    chk("occupancy", 32'(occupancy), 32'(sb_q.size()));
    chk("mispredict", 32'(mispredict), 32'(m_mis));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("branch_cnt", 32'(branch_cnt), 32'(m_bcnt));
    chk("mispred_cnt", 32'(mispred_cnt), 32'(m_mcnt));
  endtask
  task automatic tick();
    bit full, brr, updr, h;
    #1;
    brr  = sb_q.size() != 0 && !m_pend;
    updr = m_pend && !bus.pred_req;
    chk("req_ready", 32'(bus.req_ready), 32'((sb_q.size() + int'(m_req_d)) < DEPTH));
    chk("br_ready", 32'(bus.br_ready), 32'(brr));
    chk("upd_result", 32'(bus.upd_result), 32'(updr));
    chk("upd_taken", 32'(bus.upd_taken), 32'(m_dir));
    full   = sb_q.size() == DEPTH;
    m_xfer = bus.br_valid && brr;
    m_mis  = 0;
    if (m_xfer) begin
      h      = sb_q.pop_front();
      m_mis  = h != bus.br_taken;
      m_bcnt = m_bcnt < CMAX ? m_bcnt + 1 : m_bcnt;
      if (m_mis) m_mcnt = m_mcnt < CMAX ? m_mcnt + 1 : m_mcnt;
      m_pend = 1;
      m_dir  = bus.br_taken;
    end
    if (updr) m_pend = 0;
    if (m_req_d) begin
      if (full) m_ovf = 1;
      else sb_q.push_back(bus.pred_in);
    end
    m_req_d = bus.pred_req;
    @(posedge clk);
    #1;
    chk_regs();
  endtask
  task automatic set_in(input bit req, input bit pin, input bit bv, input bit bt);
    bus.pred_req = req;
    bus.pred_in  = pin;
    bus.br_valid = bv;
    bus.br_taken = bt;
  endtask
  task automatic resolve_one(input bit pred, input bit taken);
    set_in(1, 0, 0, 0); tick();
    set_in(0, pred, 0, 0); tick();
    set_in(0, 0, 1, taken); tick();
    set_in(0, 0, 0, 0); tick();
  endtask
  initial begin
    model_reset();
    set_in(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_br_ready", 32'(bus.br_ready), 32'd0);
    chk("rst_upd_result", 32'(bus.upd_result), 32'd0);
    chk("rst_upd_taken", 32'(bus.upd_taken), 32'd0);
    chk_regs();
    rst_n = 1'b1;
    resolve_one(1, 0);
    resolve_one(0, 0);
    resolve_one(1, 1);
    set_in(1, 0, 0, 0); tick();
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 1, 1); tick();
    repeat (3) begin set_in(1, 1'($urandom), 1, 0); tick(); end
    set_in(0, 1'($urandom), 1, 0); tick();
    set_in(0, 0, 0, 0); tick();
    while (sb_q.size() != 0 && checks < 5000) begin
      set_in(0, 0, 1, 1'($urandom)); tick();
      set_in(0, 0, 0, 0); tick();
    end
    repeat (5) begin set_in(1, 1'($urandom), 0, 0); tick(); end
    set_in(0, 1'($urandom), 0, 0); tick();
    set_in(0, 0, 0, 0); tick();
    chk("full_occupancy", 32'(occupancy), 32'd4);
    chk("sticky_overflow", 32'(overflow), 32'd1);
    set_in(0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    chk("arst_upd_result", 32'(bus.upd_result), 32'd0);
    chk("arst_branch_cnt", 32'(branch_cnt), 32'd0);
    chk("arst_mispred_cnt", 32'(mispred_cnt), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    repeat (300) begin
      bus.pred_req = $urandom_range(0, 2) == 0;
      bus.pred_in  = 1'($urandom);
      if (!bus.br_valid || m_xfer) begin
        bus.br_valid = 1'($urandom);
        bus.br_taken = 1'($urandom);
      end
      tick();
    end
    set_in(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (17) resolve_one(1, 0);
    chk("sat_mispred_cnt", 32'(mispred_cnt), 32'(CMAX));
    chk("sat_branch_cnt", 32'(branch_cnt), 32'(CMAX));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits between the 2-bit saturating-counter predictor and the branch execute stage.
- Captures each prediction the predictor returns and queues it in order.
- Pairs each queued prediction with the resolved branch outcome, flags mispredictions and keeps statistics.
- Drives the predictor's update pins (result/taken) only in cycles where the predictor is not servicing a request, because request has priority over result in the predictor and a colliding update would be lost.

Parameters:
- DEPTH, 4, in-flight prediction capacity; power of two, at least 2.
- PTR_W, $clog2(DEPTH), FIFO pointer width.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- pred_req  in  1  same signal that drives the predictor's request pin this cycle.
- pred_in  in  1  predictor's prediction output.
- req_ready  out  1  fetch may issue pred_req this cycle.
- br_valid  in  1  resolved-branch outcome offered.
- br_taken  in  1  actual direction of the resolved branch.
- br_ready  out  1  outcome accepted this cycle when br_valid is also high.
- upd_result  out  1  to predictor result pin.
- upd_taken  out  1  to predictor taken pin.
- mispredict  out  1  one-cycle pulse on a mismatch.
- overflow  out  1  sticky: a prediction was dropped.
- occupancy  out  PTR_W+1  queued prediction count.
- branch_cnt  out  CNT_W  resolved branches, saturating.
- mispred_cnt  out  CNT_W  mispredictions, saturating.

Behaviour:
- Reset (async, rst_n low) clears the FIFO, req_d, upd_pending, upd_dir, overflow, mispredict and both counters.
  - Reset values: occupancy 0, req_ready 1, br_ready 0, upd_result 0, upd_taken 0.
  - Reset mid-operation discards all queued and pending state; there is no update after release until a new outcome is accepted.
- Capture:
  - req_d <= pred_req each clock.
  - The predictor's prediction is valid one cycle after request, so when req_d=1, pred_in is pushed at that posedge.
  - Push latency is 2 edges from pred_req.
- Flow control:
  - req_ready = (occupancy + req_d) < DEPTH.
  - A push with the FIFO full drops the entry and sets overflow; overflow clears only on reset.
- Accept:
  - br_ready = (occupancy != 0) && !upd_pending.
  - Transfer on br_valid && br_ready.
  - The source holds br_valid/br_taken until transfer.
- On transfer at a posedge:
  - Pop the head.
  - mispredict <= (head != br_taken), otherwise 0 (registered one-cycle pulse).
  - upd_pending <= 1, upd_dir <= br_taken.
  - branch_cnt +1 and, on a mismatch, mispred_cnt +1. Both saturate at all-ones with no wrap.
- Update issue:
  - upd_result = upd_pending && !pred_req (combinational gate). upd_taken = upd_dir.
  - upd_pending clears at the posedge where upd_result=1.
  - While pred_req stays high, the update waits indefinitely and br_ready stays low.
- Push and pop in the same edge: occupancy is unchanged and the head is read before the write. A pop with DEPTH-1 entries plus a push is legal.
- Push into an empty FIFO with a simultaneous br_valid: no pop, because br_ready was 0 that cycle.
- Pointers wrap modulo DEPTH. occupancy is tracked explicitly so full and empty are unambiguous.
- Control is a 2-state machine: IDLE (upd_pending=0) and UPD_WAIT (upd_pending=1).
  - IDLE to UPD_WAIT on transfer.
  - UPD_WAIT to IDLE when upd_result=1.

Decomposition:
- Shared package (branch_pkg) holds:
  - the 2-bit counter state encodings (SNT=00, WNT=01, WT=10, ST=11);
  - the taken threshold (state[1]);
  - default DEPTH and CNT_W constants.
- One sub-module, pred_fifo: a DEPTH x 1-bit synchronous FIFO with push/pop/occupancy and async active-low clear.

Test Plan:
- Reset then pred_req pulse with pred_in=1 one cycle later -> occupancy 1 after 2 edges; br_valid=1,br_taken=0 -> mispredict pulse, mispred_cnt=1, branch_cnt=1, upd_result=1/upd_taken=0 next cycle.
- Correct prediction (queued 0, br_taken=0) -> mispredict stays 0, branch_cnt increments, mispred_cnt unchanged.
- Pending update with pred_req held high for 3 cycles -> upd_result 0 for those 3 cycles and br_ready 0; pred_req drops -> upd_result=1 for exactly one cycle.
- DEPTH=4: issue 5 requests back to back ignoring req_ready -> occupancy saturates at 4, overflow=1, req_ready 0 once occupancy+req_d reaches 4.
- Assert rst_n low mid-operation with 3 entries queued and an update pending -> occupancy 0, upd_result 0, counters 0 immediately without a clock edge.
- Force mispred_cnt near all-ones (CNT_W=4, 16 mismatches) -> holds at 15 with no wrap.
